// File: rtl/osd_write_scheduler.sv
// Single write master into the OSD slave: arbitrates refresh, host and fill-engine beats.
// Define OSD_SCHED_VBLANK_GATE_EN to restrict fill beats to vertical blank.
module osd_write_scheduler #(
  parameter int unsigned NUM_WORDS   = 250,
  parameter logic [7:0]  CFG_REGNUM  = 8'hFA,
  parameter int unsigned REFRESH_BIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  s_address,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  input  logic        s_write,
  input  logic        s_read,
  input  logic        s_chipselect,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest_n,
  input  logic        fill_req_i,
  input  logic [7:0]  fill_start_i,
  input  logic [7:0]  fill_end_i,
  input  logic [7:0]  fill_char_i,
  input  logic        fill_abort_i,
  output logic        fill_busy_o,
  output logic        fill_done_o,
  input  logic        refresh_i,
  input  logic        vblank_i,
  output logic [7:0]  m_address,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  output logic        m_write
);

  localparam logic [7:0]  LastWord    = 8'(NUM_WORDS - 1);
  localparam logic [31:0] RefreshMask = 32'd1 << REFRESH_BIT;

  typedef enum logic [1:0] {StIdle, StFill, StDone} fill_state_e;

  fill_state_e state_q, state_d;
  logic [7:0]  ptr_q, ptr_d, end_q, end_d, char_q, char_d;
  logic        rr_q, rr_d, refresh_q, refresh_d, done_q;
  logic [31:0] shadow_q [4];
  logic [31:0] shadow_d [4];
  logic [7:0]  m_addr_q, m_addr_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_be_q, m_be_d;
  logic        m_write_q, m_write_d;

  logic       host_req, host_in_cfg, fill_act;
  logic       host_gnt, fill_gnt, refresh_gnt;
  logic [1:0] cfg_idx;

`ifdef OSD_SCHED_VBLANK_GATE_EN
  assign fill_act = (state_q == StFill) & vblank_i;
`else
  logic unused_vblank;
  assign unused_vblank = vblank_i;
  assign fill_act      = (state_q == StFill);
`endif

  assign host_req    = s_chipselect & s_write;
  assign host_in_cfg = (s_address >= CFG_REGNUM) && (s_address <= CFG_REGNUM + 8'd3);
  assign cfg_idx     = s_address[1:0] - CFG_REGNUM[1:0];

  // A pending refresh always wins; host and fill share the rest round-robin.
  assign refresh_gnt = refresh_q;
  assign host_gnt    = ~refresh_q & host_req & (~fill_act | ~rr_q);
  assign fill_gnt    = ~refresh_q & fill_act & (~host_req | rr_q);

  assign s_waitrequest_n = host_gnt | (s_chipselect & s_read & ~s_write);
  assign s_readdata      = (s_chipselect & s_read & host_in_cfg) ? shadow_q[cfg_idx] : 32'h0;

  assign fill_busy_o  = (state_q != StIdle);
  assign fill_done_o  = done_q;
  assign m_address    = m_addr_q;
  assign m_writedata  = m_data_q;
  assign m_byteenable = m_be_q;
  assign m_write      = m_write_q;

  always_comb begin
    rr_d      = rr_q;
    refresh_d = (refresh_q & ~refresh_gnt) | refresh_i;
    m_write_d = refresh_gnt | host_gnt | fill_gnt;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    m_be_d    = m_be_q;
    shadow_d  = shadow_q;

    if (~refresh_q & host_req & fill_act) begin
      rr_d = host_gnt;
    end

    if (refresh_gnt) begin
      m_addr_d = CFG_REGNUM;
      m_data_d = shadow_q[0] | RefreshMask;
      m_be_d   = 4'hF;
    end else if (host_gnt) begin
      m_addr_d = s_address;
      m_data_d = s_writedata;
      m_be_d   = s_byteenable;
      if (host_in_cfg) begin
        for (int b = 0; b < 4; b++) begin
          if (s_byteenable[b]) shadow_d[cfg_idx][8*b +: 8] = s_writedata[8*b +: 8];
        end
      end
    end else if (fill_gnt) begin
      m_addr_d = ptr_q;
      m_data_d = {4{char_q}};
      m_be_d   = 4'hF;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    char_d  = char_q;
    unique case (state_q)
      StIdle: begin
        if (fill_req_i) begin
          ptr_d   = fill_start_i;
          end_d   = (fill_end_i > LastWord) ? LastWord : fill_end_i;
          char_d  = fill_char_i;
          state_d = (fill_start_i > fill_end_i || fill_start_i > LastWord) ? StDone : StFill;
        end
      end
      StFill: begin
        if (fill_gnt) begin
          ptr_d = ptr_q + 8'd1;
          if (ptr_q == end_q || fill_abort_i) state_d = StDone;
        end else if (fill_abort_i) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      end_q     <= '0;
      char_q    <= '0;
      rr_q      <= 1'b0;
      refresh_q <= 1'b0;
      done_q    <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_be_q    <= '0;
      m_write_q <= 1'b0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      char_q    <= char_d;
      rr_q      <= rr_d;
      refresh_q <= refresh_d;
      done_q    <= (state_q == StDone);
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      m_be_q    <= m_be_d;
      m_write_q <= m_write_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_osd_write_scheduler.sv
// Directed bench for osd_write_scheduler: host vector table plus hand-written fill/refresh sequences.
module tb_osd_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_address;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_write, s_read, s_chipselect;
  logic [31:0] s_readdata;
  logic        s_waitrequest_n;
  logic        fill_req, fill_abort, fill_busy, fill_done;
  logic [7:0]  fill_start, fill_end, fill_char;
  logic        refresh, vblank;
  logic [7:0]  m_address;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  osd_write_scheduler dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .s_address      (s_address),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_write        (s_write),
    .s_read         (s_read),
    .s_chipselect   (s_chipselect),
    .s_readdata     (s_readdata),
    .s_waitrequest_n(s_waitrequest_n),
    .fill_req_i     (fill_req),
    .fill_start_i   (fill_start),
    .fill_end_i     (fill_end),
    .fill_char_i    (fill_char),
    .fill_abort_i   (fill_abort),
    .fill_busy_o    (fill_busy),
    .fill_done_o    (fill_done),
    .refresh_i      (refresh),
    .vblank_i       (vblank),
    .m_address      (m_address),
    .m_writedata    (m_writedata),
    .m_byteenable   (m_byteenable),
    .m_write        (m_write)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_wrn;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_address = '0; s_writedata = '0; s_byteenable = '0;
    s_write = 0; s_read = 0; s_chipselect = 0;
    fill_req = 0; fill_start = '0; fill_end = '0; fill_char = '0; fill_abort = 0;
    refresh = 0; vblank = 0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    s_chipselect = 1; s_write = 1; s_read = 0; s_address = a; s_writedata = d; s_byteenable = be;
  endtask

  task automatic host_rd(input logic [7:0] a);
    s_chipselect = 1; s_write = 0; s_read = 1; s_address = a;
  endtask

  task automatic host_off();
    s_chipselect = 0; s_write = 0; s_read = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic start_fill(input logic [7:0] st, input logic [7:0] en, input logic [7:0] ch);
    fill_req = 1; fill_start = st; fill_end = en; fill_char = ch;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, bad, done_at, done_cnt, wrn_bad;
    logic [7:0]  ea;
    logic [31:0] ed;

    vecs[0]  = '{1'b1, 1'b0, 8'hFA, 32'h1122_3344, 4'hF, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 8'hFA, 32'h0,         4'h0, 1'b1, 32'h1122_3344};
    vecs[2]  = '{1'b1, 1'b0, 8'hFB, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 8'hFB, 32'h0,         4'h0, 1'b1, 32'h00BB_00DD};
    vecs[4]  = '{1'b0, 1'b1, 8'h10, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 8'h10, 32'hCAFE_F00D, 4'h3, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 8'hFD, 32'h0,         4'h0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 8'hFD, 32'hFFFF_FFFF, 4'h8, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 8'hFD, 32'h0,         4'h0, 1'b1, 32'hFF00_0000};
    vecs[9]  = '{1'b1, 1'b0, 8'hFA, 32'h0000_0005, 4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 8'hFA, 32'h0,         4'h0, 1'b1, 32'h0000_0005};

    clear_inputs();
    rst_n = 0;
    tick();
    chk("rst_m_write", m_write, 0);
    chk("rst_m_address", m_address, 0);
    chk("rst_m_writedata", m_writedata, 0);
    chk("rst_m_be", m_byteenable, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_wrn", s_waitrequest_n, 0);
    chk("rst_rdata", s_readdata, 0);
    rst_n = 1;
    tick();

    // Host vector table, no fill or refresh traffic.
    for (int i = 0; i < 11; i++) begin
      s_chipselect = 1; s_write = vecs[i].wr; s_read = vecs[i].rd;
      s_address = vecs[i].addr; s_writedata = vecs[i].wdata; s_byteenable = vecs[i].be;
      #1;
      chk($sformatf("vec%0d_wrn", i), s_waitrequest_n, vecs[i].exp_wrn);
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), s_readdata, vecs[i].exp_rdata);
      tick();
      chk($sformatf("vec%0d_mwrite", i), m_write, vecs[i].wr);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_maddr", i), m_address, vecs[i].addr);
        chk($sformatf("vec%0d_mdata", i), m_writedata, vecs[i].wdata);
        chk($sformatf("vec%0d_mbe", i), m_byteenable, vecs[i].be);
      end
      host_off();
    end
    #1;
    chk("idle_wrn", s_waitrequest_n, 0);

    // Refresh after host wrote 5 to 0xFA.
    refresh = 1;
    tick();
    refresh = 0;
    chk("ref_first_cycle_nowrite", m_write, 0);
    tick();
    chk("ref_mwrite", m_write, 1);
    chk("ref_maddr", m_address, 8'hFA);
    chk("ref_mdata", m_writedata, 32'h0000_0007);
    chk("ref_mbe", m_byteenable, 4'hF);
    host_rd(8'hFA);
    #1;
    chk("ref_shadow_unchanged", s_readdata, 32'h0000_0005);
    host_off();
    tick();

    // Refresh coincident with host write to CFG_REGNUM.
    host_wr(8'hFA, 32'h0000_0010, 4'hF);
    refresh = 1;
    #1;
    chk("coinc_host_wrn", s_waitrequest_n, 1);
    tick();
    host_off();
    refresh = 0;
    chk("coinc_host_beat", m_writedata, 32'h0000_0010);
    tick();
    chk("coinc_ref_mwrite", m_write, 1);
    chk("coinc_ref_maddr", m_address, 8'hFA);
    chk("coinc_ref_mdata", m_writedata, 32'h0000_0012);

    // Full-screen fill; end 0xFF is clamped to the last word.
    tick();
    start_fill(8'd0, 8'hFF, 8'h20);
    tick();
    fill_req = 0;
    chk("full_busy", fill_busy, 1);
    beats = 0; bad = 0; done_at = -1; done_cnt = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (m_write !== (i <= 250)) bad++;
      else if (m_write && (m_address !== 8'(i - 1) || m_writedata !== 32'h2020_2020 ||
                           m_byteenable !== 4'hF)) bad++;
      if (m_write === 1'b1) beats++;
      if (fill_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    chk("full_beats", beats, 250);
    chk("full_bad_beats", bad, 0);
    chk("full_done_cycle", done_at, 251);
    chk("full_done_pulses", done_cnt, 1);
    chk("full_busy_end", fill_busy, 0);

    // Host writing every cycle against fill 10..13 from a fresh round-robin state.
    do_reset();
    host_wr(8'h50, 32'hDEAD_BEEF, 4'hF);
    start_fill(8'd10, 8'd13, 8'h41);
    #1;
    chk("cont_c0_wrn", s_waitrequest_n, 1);
    tick();
    fill_req = 0;
    chk("cont_c0_beat", m_address, 8'h50);
    wrn_bad = 0; bad = 0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (s_waitrequest_n !== logic'(i % 2)) wrn_bad++;
      tick();
      ea = (i % 2 == 1) ? 8'h50 : 8'(10 + i / 2 - 1);
      ed = (i % 2 == 1) ? 32'hDEAD_BEEF : 32'h4141_4141;
      if (m_write !== 1'b1 || m_address !== ea || m_writedata !== ed) bad++;
    end
    host_off();
    chk("cont_wrn_alternate", wrn_bad, 0);
    chk("cont_beat_order", bad, 0);
    tick();
    chk("cont_done", fill_done, 1);

    // Empty range: start > end.
    tick();
    start_fill(8'd20, 8'd5, 8'h33);
    tick();
    fill_req = 0;
    chk("empty_busy_c1", fill_busy, 1);
    chk("empty_done_c1", fill_done, 0);
    chk("empty_nowrite_c1", m_write, 0);
    tick();
    chk("empty_busy_c2", fill_busy, 0);
    chk("empty_done_c2", fill_done, 1);
    chk("empty_nowrite_c2", m_write, 0);
    tick();
    chk("empty_done_c3", fill_done, 0);

    // Abort on the third beat of 0..9.
    start_fill(8'd0, 8'd9, 8'h55);
    tick();
    fill_req = 0;
    tick();
    chk("abort_b0", m_address, 8'd0);
    tick();
    chk("abort_b1", m_address, 8'd1);
    fill_abort = 1;
    tick();
    fill_abort = 0;
    chk("abort_b2_write", m_write, 1);
    chk("abort_b2", m_address, 8'd2);
    tick();
    chk("abort_no_b3", m_write, 0);
    chk("abort_done", fill_done, 1);
    start_fill(8'd30, 8'd30, 8'h66);
    tick();
    fill_req = 0;
    chk("refill_busy", fill_busy, 1);
    tick();
    chk("refill_beat_write", m_write, 1);
    chk("refill_beat_addr", m_address, 8'd30);
    tick();
    tick();

    // Asynchronous reset in the middle of a fill with a refresh pending.
    host_wr(8'hFA, 32'h0000_0055, 4'hF);
    tick();
    host_off();
    start_fill(8'd0, 8'd249, 8'h20);
    tick();
    fill_req = 0;
    tick();
    tick();
    chk("midfill_writing", m_write, 1);
    refresh = 1;
    tick();
    refresh = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_mid_mwrite", m_write, 0);
    chk("rst_mid_busy", fill_busy, 0);
    tick();
    rst_n = 1;
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_write !== 1'b0) beats++;
    end
    chk("rst_no_refresh_beat", beats, 0);
    chk("rst_busy_after", fill_busy, 0);
    host_rd(8'hFA);
    #1;
    chk("rst_shadow_cleared", s_readdata, 0);
    host_off();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
